// File: rtl/imm_gen_pipe.sv
// RISC-V immediate generator: I/S/B/U/J formats, optional opcode-driven format decode,
// registered output with a one-entry skid buffer and a saturating illegal-format counter.
module imm_gen_pipe #(
  parameter int XLEN        = 32,
  parameter int AUTO_DECODE = 0,
  parameter int TAG_W       = 5,
  parameter int CNT_W       = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      Instr,
  input  logic [2:0]       ImmSrc,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  ImmExt,
  output logic [TAG_W-1:0] out_tag,
  output logic             illegal_o,
  output logic [CNT_W-1:0] illegal_cnt,
  input  logic             cnt_clear
);

  typedef enum logic [2:0] {
    FMT_I   = 3'd0,
    FMT_S   = 3'd1,
    FMT_B   = 3'd2,
    FMT_U   = 3'd3,
    FMT_J   = 3'd4,
    FMT_ILL = 3'd7
  } fmt_e;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  fmt_e            src_fmt;
  fmt_e            auto_fmt;
  fmt_e            fmt;
  logic [31:0]     imm32;
  logic [XLEN-1:0] imm_xlen;
  logic [XLEN-1:0] new_imm;
  logic            new_ill;
  logic            accept;

  // Output register O and skid register K
  logic             o_valid_reg, o_valid_next;
  logic [XLEN-1:0]  o_imm_reg,   o_imm_next;
  logic [TAG_W-1:0] o_tag_reg,   o_tag_next;
  logic             o_ill_reg,   o_ill_next;
  logic             k_valid_reg, k_valid_next;
  logic [XLEN-1:0]  k_imm_reg,   k_imm_next;
  logic [TAG_W-1:0] k_tag_reg,   k_tag_next;
  logic             k_ill_reg,   k_ill_next;
  logic [CNT_W-1:0] cnt_reg,     cnt_next;

  always_comb begin
    src_fmt = FMT_ILL;
    case (ImmSrc)
      3'b000:  src_fmt = FMT_I;
      3'b001:  src_fmt = FMT_S;
      3'b010:  src_fmt = FMT_B;
      3'b011:  src_fmt = FMT_U;
      3'b100:  src_fmt = FMT_J;
      default: src_fmt = FMT_ILL;
    endcase
  end

  always_comb begin
    auto_fmt = FMT_ILL;
    case (Instr[6:0])
      7'b0000011, 7'b0010011, 7'b1100111, 7'b1110011: auto_fmt = FMT_I;
      7'b0100011:                                     auto_fmt = FMT_S;
      7'b1100011:                                     auto_fmt = FMT_B;
      7'b0110111, 7'b0010111:                         auto_fmt = FMT_U;
      7'b1101111:                                     auto_fmt = FMT_J;
      default:                                        auto_fmt = FMT_ILL;
    endcase
  end

  assign fmt = (AUTO_DECODE != 0) ? auto_fmt : src_fmt;

  always_comb begin
    imm32 = 32'd0;
    case (fmt)
      FMT_I:   imm32 = {{20{Instr[31]}}, Instr[31:20]};
      FMT_S:   imm32 = {{20{Instr[31]}}, Instr[31:25], Instr[11:7]};
      FMT_B:   imm32 = {{19{Instr[31]}}, Instr[31], Instr[7], Instr[30:25], Instr[11:8], 1'b0};
      FMT_U:   imm32 = {Instr[31:12], 12'd0};
      FMT_J:   imm32 = {{11{Instr[31]}}, Instr[31], Instr[19:12], Instr[20], Instr[30:21], 1'b0};
      default: imm32 = 32'd0;
    endcase
  end

  // Bits above 31 replicate the instruction sign bit (no iterations when XLEN=32)
  assign imm_xlen[31:0] = imm32;
  generate
    for (genvar gi = 32; gi < XLEN; gi++) begin : g_sext
      assign imm_xlen[gi] = Instr[31];
    end
  endgenerate

  assign new_ill = (fmt == FMT_ILL);
  assign new_imm = new_ill ? '0 : imm_xlen;
  assign in_ready = !k_valid_reg;
  assign accept   = in_valid && in_ready;

  always_comb begin
    o_valid_next = o_valid_reg;
    o_imm_next   = o_imm_reg;
    o_tag_next   = o_tag_reg;
    o_ill_next   = o_ill_reg;
    k_valid_next = k_valid_reg;
    k_imm_next   = k_imm_reg;
    k_tag_next   = k_tag_reg;
    k_ill_next   = k_ill_reg;

    if (k_valid_reg && out_ready) begin
      // Skid entry drains first; no accept is possible while it is full
      o_valid_next = 1'b1;
      o_imm_next   = k_imm_reg;
      o_tag_next   = k_tag_reg;
      o_ill_next   = k_ill_reg;
      k_valid_next = 1'b0;
    end else if (accept && (!o_valid_reg || out_ready)) begin
      o_valid_next = 1'b1;
      o_imm_next   = new_imm;
      o_tag_next   = in_tag;
      o_ill_next   = new_ill;
    end else if (accept) begin
      k_valid_next = 1'b1;
      k_imm_next   = new_imm;
      k_tag_next   = in_tag;
      k_ill_next   = new_ill;
    end else if (out_ready && o_valid_reg) begin
      o_valid_next = 1'b0;
    end
  end

  always_comb begin
    cnt_next = cnt_reg;
    if (cnt_clear) begin
      cnt_next = '0;
    end else if (accept && new_ill && (cnt_reg != CNT_MAX)) begin
      cnt_next = cnt_reg + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      o_valid_reg <= 1'b0;
      o_imm_reg   <= '0;
      o_tag_reg   <= '0;
      o_ill_reg   <= 1'b0;
      k_valid_reg <= 1'b0;
      k_imm_reg   <= '0;
      k_tag_reg   <= '0;
      k_ill_reg   <= 1'b0;
      cnt_reg     <= '0;
    end else begin
      o_valid_reg <= o_valid_next;
      o_imm_reg   <= o_imm_next;
      o_tag_reg   <= o_tag_next;
      o_ill_reg   <= o_ill_next;
      k_valid_reg <= k_valid_next;
      k_imm_reg   <= k_imm_next;
      k_tag_reg   <= k_tag_next;
      k_ill_reg   <= k_ill_next;
      cnt_reg     <= cnt_next;
    end
  end

  assign out_valid   = o_valid_reg;
  assign ImmExt      = o_imm_reg;
  assign out_tag     = o_tag_reg;
  assign illegal_o   = o_ill_reg;
  assign illegal_cnt = cnt_reg;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Directed bench for imm_gen_pipe: three instances (XLEN=32 with a 2-bit counter,
// XLEN=32 with opcode decode, XLEN=64) share one stimulus stream.
module tb_imm_gen_pipe;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        in_valid;
  logic [31:0] instr;
  logic [2:0]  imm_src;
  logic [4:0]  in_tag;
  logic        out_ready;
  logic        cnt_clear;

  logic        a_in_ready, a_out_valid, a_ill;
  logic [31:0] a_imm;
  logic [4:0]  a_tag;
  logic [1:0]  a_cnt;
  logic        b_in_ready, b_out_valid, b_ill;
  logic [31:0] b_imm;
  logic [4:0]  b_tag;
  logic [7:0]  b_cnt;
  logic        c_in_ready, c_out_valid, c_ill;
  logic [63:0] c_imm;
  logic [4:0]  c_tag;
  logic [7:0]  c_cnt;

  initial forever #5 clk = ~clk;

  imm_gen_pipe #(.XLEN(32), .AUTO_DECODE(0), .TAG_W(5), .CNT_W(2)) dut_a (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(a_in_ready),
    .Instr(instr), .ImmSrc(imm_src), .in_tag(in_tag), .out_valid(a_out_valid),
    .out_ready(out_ready), .ImmExt(a_imm), .out_tag(a_tag), .illegal_o(a_ill),
    .illegal_cnt(a_cnt), .cnt_clear(cnt_clear));

  imm_gen_pipe #(.XLEN(32), .AUTO_DECODE(1), .TAG_W(5), .CNT_W(8)) dut_b (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(b_in_ready),
    .Instr(instr), .ImmSrc(imm_src), .in_tag(in_tag), .out_valid(b_out_valid),
    .out_ready(out_ready), .ImmExt(b_imm), .out_tag(b_tag), .illegal_o(b_ill),
    .illegal_cnt(b_cnt), .cnt_clear(cnt_clear));

  imm_gen_pipe #(.XLEN(64), .AUTO_DECODE(0), .TAG_W(5), .CNT_W(8)) dut_c (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(c_in_ready),
    .Instr(instr), .ImmSrc(imm_src), .in_tag(in_tag), .out_valid(c_out_valid),
    .out_ready(out_ready), .ImmExt(c_imm), .out_tag(c_tag), .illegal_o(c_ill),
    .illegal_cnt(c_cnt), .cnt_clear(cnt_clear));

  typedef struct {
    int          dut;      // 0 = dut_a, 1 = dut_b, 2 = dut_c
    logic [31:0] instr;
    logic [2:0]  src;
    logic [63:0] exp_imm;
    logic        exp_ill;
  } vec_t;

  localparam int NV = 23;
  vec_t vecs[NV];

  int total = 0;
  int bad   = 0;

  logic [63:0] act_imm;
  logic [4:0]  act_tag;
  logic        act_ill, act_v;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [31:0] i, input logic [2:0] s, input logic [4:0] t);
    in_valid = v;
    instr    = i;
    imm_src  = s;
    in_tag   = t;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    vecs[0]  = '{0, 32'hFFF00093, 3'b000, 64'h0000_0000_FFFF_FFFF, 1'b0};
    vecs[1]  = '{0, 32'hFE20AE23, 3'b001, 64'h0000_0000_FFFF_FFFC, 1'b0};
    vecs[2]  = '{0, 32'hFE000CE3, 3'b010, 64'h0000_0000_FFFF_FFF8, 1'b0};
    vecs[3]  = '{0, 32'h123450B7, 3'b011, 64'h0000_0000_1234_5000, 1'b0};
    vecs[4]  = '{0, 32'h0010006F, 3'b100, 64'h0000_0000_0000_0800, 1'b0};
    vecs[5]  = '{0, 32'h00A00093, 3'b000, 64'h0000_0000_0000_000A, 1'b0};
    vecs[6]  = '{0, 32'h00112423, 3'b001, 64'h0000_0000_0000_0008, 1'b0};
    vecs[7]  = '{0, 32'h00208463, 3'b010, 64'h0000_0000_0000_0008, 1'b0};
    vecs[8]  = '{0, 32'hFFDFF0EF, 3'b100, 64'h0000_0000_FFFF_FFFC, 1'b0};
    vecs[9]  = '{0, 32'h800000B7, 3'b011, 64'h0000_0000_8000_0000, 1'b0};
    vecs[10] = '{1, 32'h0010006F, 3'b000, 64'h0000_0000_0000_0800, 1'b0};
    vecs[11] = '{1, 32'h0000007F, 3'b000, 64'h0000_0000_0000_0000, 1'b1};
    vecs[12] = '{1, 32'hFE20AE23, 3'b011, 64'h0000_0000_FFFF_FFFC, 1'b0};
    vecs[13] = '{1, 32'h123450B7, 3'b100, 64'h0000_0000_1234_5000, 1'b0};
    vecs[14] = '{1, 32'hFE000CE3, 3'b000, 64'h0000_0000_FFFF_FFF8, 1'b0};
    vecs[15] = '{1, 32'hFFF00093, 3'b111, 64'h0000_0000_FFFF_FFFF, 1'b0};
    vecs[16] = '{1, 32'hFFFFF017, 3'b000, 64'h0000_0000_FFFF_F000, 1'b0};
    vecs[17] = '{2, 32'hFFF00093, 3'b000, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0};
    vecs[18] = '{2, 32'h800000B7, 3'b011, 64'hFFFF_FFFF_8000_0000, 1'b0};
    vecs[19] = '{2, 32'h123450B7, 3'b011, 64'h0000_0000_1234_5000, 1'b0};
    vecs[20] = '{2, 32'hFE000CE3, 3'b010, 64'hFFFF_FFFF_FFFF_FFF8, 1'b0};
    vecs[21] = '{2, 32'h0010006F, 3'b100, 64'h0000_0000_0000_0800, 1'b0};
    vecs[22] = '{2, 32'h00000093, 3'b110, 64'h0000_0000_0000_0000, 1'b1};

    // Reset state, checked before any clock edge reaches the design
    reset_n   = 1'b0;
    out_ready = 1'b1;
    cnt_clear = 1'b0;
    drive(1'b0, 32'h0, 3'b000, 5'd0);
    #3;
    chk("rst_out_valid", {63'd0, a_out_valid}, 64'd0);
    chk("rst_in_ready",  {63'd0, a_in_ready},  64'd1);
    chk("rst_cnt",       {62'd0, a_cnt},       64'd0);
    chk("rst_imm64",     c_imm,                64'd0);
    chk("rst_tag",       {59'd0, c_tag},       64'd0);
    @(negedge clk);
    reset_n = 1'b1;
    step();

    // Table: back-to-back accepts, one result per cycle
    for (int i = 0; i < NV; i++) begin
      drive(1'b1, vecs[i].instr, vecs[i].src, 5'(i + 1));
      step();
      case (vecs[i].dut)
        0: begin act_imm = {32'd0, a_imm}; act_tag = a_tag; act_ill = a_ill; act_v = a_out_valid; end
        1: begin act_imm = {32'd0, b_imm}; act_tag = b_tag; act_ill = b_ill; act_v = b_out_valid; end
        default: begin act_imm = c_imm; act_tag = c_tag; act_ill = c_ill; act_v = c_out_valid; end
      endcase
      $display("vec %0d dut=%0d instr=%08h src=%0d imm=%016h tag=%0d ill=%0b",
               i, vecs[i].dut, vecs[i].instr, vecs[i].src, act_imm, act_tag, act_ill);
      chk($sformatf("vec%0d_valid", i), {63'd0, act_v},   64'd1);
      chk($sformatf("vec%0d_imm", i),   act_imm,          vecs[i].exp_imm);
      chk($sformatf("vec%0d_tag", i),   {59'd0, act_tag}, 64'(i + 1));
      chk($sformatf("vec%0d_ill", i),   {63'd0, act_ill}, {63'd0, vecs[i].exp_ill});
    end
    drive(1'b0, 32'h0, 3'b000, 5'd0);
    step();
    chk("drain_valid", {63'd0, a_out_valid}, 64'd0);

    // Backpressure: tag1 -> O, tag2 -> K, tag3 held off, then drained in order
    out_ready = 1'b0;
    drive(1'b1, 32'hFFF00093, 3'b000, 5'd1);
    step();
    $display("bp tag1 accepted: out_tag=%0d in_ready=%0b", a_tag, a_in_ready);
    chk("bp1_valid", {63'd0, a_out_valid}, 64'd1);
    chk("bp1_tag",   {59'd0, a_tag},       64'd1);
    chk("bp1_ready", {63'd0, a_in_ready},  64'd1);
    drive(1'b1, 32'h00A00093, 3'b000, 5'd2);
    step();
    $display("bp tag2 skid: out_tag=%0d in_ready=%0b", a_tag, a_in_ready);
    chk("bp2_ready", {63'd0, a_in_ready}, 64'd0);
    chk("bp2_tag",   {59'd0, a_tag},      64'd1);
    chk("bp2_imm",   {32'd0, a_imm},      64'h0000_0000_FFFF_FFFF);
    drive(1'b1, 32'h00112423, 3'b001, 5'd3);
    step();
    $display("bp tag3 held: out_tag=%0d in_ready=%0b", a_tag, a_in_ready);
    chk("bp3_ready", {63'd0, a_in_ready},  64'd0);
    chk("bp3_tag",   {59'd0, a_tag},       64'd1);
    chk("bp3_imm",   {32'd0, a_imm},       64'h0000_0000_FFFF_FFFF);
    chk("bp3_valid", {63'd0, a_out_valid}, 64'd1);
    out_ready = 1'b1;
    step();
    $display("bp drain: out_tag=%0d in_ready=%0b", a_tag, a_in_ready);
    chk("bp4_tag",   {59'd0, a_tag},      64'd2);
    chk("bp4_imm",   {32'd0, a_imm},      64'h0000_0000_0000_000A);
    chk("bp4_ready", {63'd0, a_in_ready}, 64'd1);
    step();
    $display("bp drain: out_tag=%0d", a_tag);
    chk("bp5_tag",   {59'd0, a_tag},       64'd3);
    chk("bp5_imm",   {32'd0, a_imm},       64'h0000_0000_0000_0008);
    chk("bp5_valid", {63'd0, a_out_valid}, 64'd1);
    drive(1'b0, 32'h0, 3'b000, 5'd0);
    step();
    chk("bp6_valid", {63'd0, a_out_valid}, 64'd0);

    // Illegal counter: saturation at 3 for CNT_W=2, clear beats increment
    cnt_clear = 1'b1;
    step();
    cnt_clear = 1'b0;
    chk("cnt_cleared", {62'd0, a_cnt}, 64'd0);
    for (int k = 0; k < 5; k++) begin
      drive(1'b1, 32'hFFFFFFFF, 3'(5 + k % 3), 5'(10 + k));
      step();
      $display("illegal %0d: imm=%08h ill=%0b cnt=%0d", k, a_imm, a_ill, a_cnt);
      chk($sformatf("ill%0d_imm", k), {32'd0, a_imm},  64'd0);
      chk($sformatf("ill%0d_flag", k), {63'd0, a_ill}, 64'd1);
      chk($sformatf("ill%0d_tag", k), {59'd0, a_tag},  64'(10 + k));
      chk($sformatf("ill%0d_cnt", k), {62'd0, a_cnt},  64'((k + 1 > 3) ? 3 : k + 1));
    end
    chk("cnt8_nosat", {56'd0, b_cnt}, 64'd5);
    cnt_clear = 1'b1;
    drive(1'b1, 32'hFFFFFFFF, 3'b101, 5'd20);
    step();
    cnt_clear = 1'b0;
    $display("clear+illegal: ill=%0b cnt=%0d", a_ill, a_cnt);
    chk("clr_cnt",  {62'd0, a_cnt}, 64'd0);
    chk("clr_ill",  {63'd0, a_ill}, 64'd1);
    chk("clr_cntb", {56'd0, b_cnt}, 64'd0);
    drive(1'b1, 32'h00A00093, 3'b000, 5'd21);
    step();
    chk("legal_ill", {63'd0, a_ill},  64'd0);
    chk("legal_cnt", {62'd0, a_cnt},  64'd0);
    chk("legal_imm", {32'd0, a_imm},  64'h0000_0000_0000_000A);
    drive(1'b1, 32'h00000013, 3'b110, 5'd22);
    step();
    chk("cnt_after", {62'd0, a_cnt}, 64'd1);

    // Asynchronous reset with both O and K holding entries
    drive(1'b0, 32'h0, 3'b000, 5'd0);
    cnt_clear = 1'b1;
    step();
    cnt_clear = 1'b0;
    out_ready = 1'b0;
    drive(1'b1, 32'h00000013, 3'b101, 5'd7);
    step();
    drive(1'b1, 32'h00000013, 3'b101, 5'd8);
    step();
    drive(1'b0, 32'h0, 3'b000, 5'd0);
    $display("pre-reset: out_tag=%0d in_ready=%0b cnt=%0d", c_tag, c_in_ready, c_cnt);
    chk("full_ready", {63'd0, c_in_ready},  64'd0);
    chk("full_valid", {63'd0, c_out_valid}, 64'd1);
    chk("full_tag",   {59'd0, c_tag},       64'd7);
    chk("full_cnt",   {56'd0, c_cnt},       64'd2);
    #2;
    reset_n = 1'b0;
    #1;
    $display("async reset: out_valid=%0b in_ready=%0b cnt=%0d", c_out_valid, c_in_ready, c_cnt);
    chk("arst_valid",  {63'd0, c_out_valid}, 64'd0);
    chk("arst_ready",  {63'd0, c_in_ready},  64'd1);
    chk("arst_cnt",    {56'd0, c_cnt},       64'd0);
    chk("arst_imm",    c_imm,                64'd0);
    chk("arst_tag",    {59'd0, c_tag},       64'd0);
    chk("arst_ill",    {63'd0, c_ill},       64'd0);
    chk("arst_valida", {63'd0, a_out_valid}, 64'd0);
    chk("arst_readya", {63'd0, a_in_ready},  64'd1);
    @(negedge clk);
    reset_n   = 1'b1;
    out_ready = 1'b1;
    step();
    chk("post_rst_idle", {63'd0, c_out_valid}, 64'd0);
    drive(1'b1, 32'hFFF00093, 3'b000, 5'd9);
    step();
    drive(1'b0, 32'h0, 3'b000, 5'd0);
    $display("post-reset: imm=%016h tag=%0d", c_imm, c_tag);
    chk("post_rst_imm", c_imm,          64'hFFFF_FFFF_FFFF_FFFF);
    chk("post_rst_tag", {59'd0, c_tag}, 64'd9);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
